// File: rtl/fetch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_sequencer
// Description : Owns the fetch PC, issues one block-aligned I-cache request at a
//               time, hands each group to the fetch queue and picks the next PC.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_sequencer #(
    parameter int unsigned NR_INSTR  = 4,
    parameter logic [63:0] BOOT_ADDR = 64'h0000_0000_8000_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic [63:0]                 flush_addr_i,
    output logic                        req_valid_o,
    output logic [63:0]                 req_addr_o,
    input  logic                        req_ready_i,
    input  logic                        rsp_valid_i,
    input  logic                        rsp_taken_i,
    input  logic [63:0]                 rsp_target_i,
    output logic                        out_valid_o,
    output logic [63:0]                 out_pc_o,
    output logic [$clog2(NR_INSTR)-1:0] out_offset_o,
    input  logic                        out_ready_i
);

    localparam int unsigned c_blk_bytes = NR_INSTR * 4;
    localparam int unsigned c_blk_w     = $clog2(c_blk_bytes);
    localparam int unsigned c_off_w     = $clog2(NR_INSTR);
    localparam logic [63:0] c_blk       = 64'(c_blk_bytes);
    localparam logic [63:0] c_align     = ~(c_blk - 64'd1);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [63:0]          pc_q, pc_d;
    logic [63:0]          out_pc_q, out_pc_d;
    logic [c_off_w-1:0]   out_off_q, out_off_d;
    logic                 req_valid_q;
    logic                 out_valid_q;

    logic [63:0]          w_pc_aligned;
    logic [63:0]          w_pc_seq;
    logic                 w_in_flight;

    assign w_pc_aligned = pc_q & c_align;
    assign w_pc_seq     = w_pc_aligned + c_blk;

    // A request stays owed a response until the I-cache answers it, even if a
    // flush has already made that response worthless.
    assign w_in_flight = ((state_q == ST_WAIT)  && !rsp_valid_i) ||
                         ((state_q == ST_REQ)   &&  req_ready_i) ||
                         ((state_q == ST_DRAIN) && !rsp_valid_i);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        out_pc_d  = out_pc_q;
        out_off_d = out_off_q;
        if (flush_i) begin
            pc_d    = flush_addr_i;
            state_d = w_in_flight ? ST_DRAIN : ST_REQ;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_REQ;
                ST_REQ: begin
                    if (req_ready_i) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (rsp_valid_i) begin
                        out_pc_d  = pc_q;
                        out_off_d = pc_q[c_blk_w-1:2];
                        pc_d      = rsp_taken_i ? rsp_target_i : w_pc_seq;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready_i) state_d = ST_REQ;
                end
                ST_DRAIN: begin
                    if (rsp_valid_i) state_d = ST_REQ;
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_BOOT;
            pc_q        <= BOOT_ADDR;
            out_pc_q    <= '0;
            out_off_q   <= '0;
            req_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_pc_q    <= out_pc_d;
            out_off_q   <= out_off_d;
            req_valid_q <= (state_d == ST_REQ);
            out_valid_q <= (state_d == ST_HOLD);
        end
    end

    assign req_valid_o  = req_valid_q;
    assign req_addr_o   = w_pc_aligned;
    assign out_valid_o  = out_valid_q;
    assign out_pc_o     = out_pc_q;
    assign out_offset_o = out_off_q;

endmodule
`default_nettype wire
